// File: rtl/spdr_cmd_decoder.sv
// spdr_cmd_decoder: turns the spdr FIFO byte stream into register-bus
// writes/reads and returns read data on a response stream.
// Packet: HDR, ADDR, [CHK], then N write-data bytes (writes only).
// HDR[7] = write, HDR[3:0] = N-1.
// Optional feature: define SPDR_CMD_CHKSUM_EN to add the CHK byte,
// which must equal HDR ^ ADDR ^ 8'hA5.
// Response handshake: rsp_data is presented with rsp_valid; once raised,
// rsp_valid and rsp_data stay stable until the cycle rsp_ready is also high,
// and the byte is transferred on that clock edge.
module spdr_cmd_decoder #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk_in,
    input  logic       rstn_in,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_pop,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       err,
    output logic [7:0] err_cnt,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_CHK    = 3'd2,
        S_WDATA  = 3'd3,
        S_RDREQ  = 3'd4,
        S_RDWAIT = 3'd5,
        S_RSP    = 3'd6,
        S_DRAIN  = 3'd7
    } state_t;

    localparam logic [7:0] TMO = TIMEOUT[7:0];

    state_t     state_q, state_d;
    logic       wr_q, wr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] tmo_q, tmo_d;
    logic [7:0] bus_addr_d, bus_wdata_d, rsp_data_d, err_cnt_d;
    logic       bus_we_d, bus_re_d, rsp_valid_d, err_d;
    logic       consume;
    logic [7:0] tmo_inc;
`ifdef SPDR_CMD_CHKSUM_EN
    logic [7:0] hdr_q, hdr_d;
`endif

    assign state_dbg = state_q;
    assign tmo_inc   = tmo_q + 8'd1;
    // Reset gating keeps the FIFO untouched while the block is held in reset.
    assign fifo_pop  = consume && !fifo_empty && rstn_in;

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            cnt_q     <= 4'd0;
            addr_q    <= 8'd0;
            tmo_q     <= 8'd0;
            bus_addr  <= 8'd0;
            bus_wdata <= 8'd0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            rsp_data  <= 8'd0;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
`ifdef SPDR_CMD_CHKSUM_EN
            hdr_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            tmo_q     <= tmo_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
            bus_we    <= bus_we_d;
            bus_re    <= bus_re_d;
            rsp_data  <= rsp_data_d;
            rsp_valid <= rsp_valid_d;
            err       <= err_d;
            err_cnt   <= err_cnt_d;
`ifdef SPDR_CMD_CHKSUM_EN
            hdr_q     <= hdr_d;
`endif
        end
    end

    // Next-state, byte consumption, bus strobes, timeout and error counting.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        tmo_d       = 8'd0;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        bus_we_d    = 1'b0;
        bus_re_d    = 1'b0;
        rsp_data_d  = rsp_data;
        rsp_valid_d = rsp_valid;
        err_d       = 1'b0;
        consume     = 1'b0;
`ifdef SPDR_CMD_CHKSUM_EN
        hdr_d       = hdr_q;
`endif
        case (state_q)
            S_IDLE: begin
                consume = 1'b1;
                if (!fifo_empty) begin
                    wr_d    = fifo_dout[7];
                    cnt_d   = fifo_dout[3:0];
`ifdef SPDR_CMD_CHKSUM_EN
                    hdr_d   = fifo_dout;
`endif
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                consume = 1'b1;
                if (!fifo_empty) begin
                    addr_d = fifo_dout;
`ifdef SPDR_CMD_CHKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = wr_q ? S_WDATA : S_RDREQ;
`endif
                end
            end
`ifdef SPDR_CMD_CHKSUM_EN
            S_CHK: begin
                consume = 1'b1;
                if (!fifo_empty) begin
                    if (fifo_dout == (hdr_q ^ addr_q ^ 8'hA5)) begin
                        state_d = wr_q ? S_WDATA : S_RDREQ;
                    end else begin
                        // Bad packet: writes still swallow their data bytes.
                        err_d   = 1'b1;
                        state_d = wr_q ? S_DRAIN : S_IDLE;
                    end
                end
            end
`endif
            S_WDATA: begin
                consume = 1'b1;
                if (!fifo_empty) begin
                    bus_we_d    = 1'b1;
                    bus_addr_d  = addr_q;
                    bus_wdata_d = fifo_dout;
                    addr_d      = addr_q + 8'd1;
                    if (cnt_q == 4'd0) state_d = S_IDLE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            S_RDREQ: begin
                bus_re_d   = 1'b1;
                bus_addr_d = addr_q;
                state_d    = S_RDWAIT;
            end
            S_RDWAIT: begin
                rsp_data_d  = bus_rdata;
                rsp_valid_d = 1'b1;
                state_d     = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    addr_d      = addr_q + 8'd1;
                    if (cnt_q == 4'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        state_d = S_RDREQ;
                    end
                end
            end
            S_DRAIN: begin
                consume = 1'b1;
                if (!fifo_empty) begin
                    if (cnt_q == 4'd0) state_d = S_IDLE;
                    else               cnt_d   = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Mid-packet starvation: only byte-consuming states past the header count.
        if (consume && (state_q != S_IDLE) && fifo_empty) begin
            tmo_d = tmo_inc;
            if (tmo_inc == TMO) begin
                tmo_d   = 8'd0;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
        end

        err_cnt_d = (err_d && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
    end

endmodule

// File: tb/tb_spdr_cmd_decoder.sv
// Bench for spdr_cmd_decoder: packet-level model feeding expected queues,
// FIFO and register-bus models, one compare process on the falling edge.
module tb_spdr_cmd_decoder;

    logic       clk_in = 1'b0;
    logic       rstn_in;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] bus_addr, bus_wdata, bus_rdata, rsp_data, err_cnt;
    logic       bus_we, bus_re, rsp_valid, rsp_ready, err;
    logic [2:0] state_dbg;

    spdr_cmd_decoder #(.TIMEOUT(4)) dut (
        .clk_in(clk_in), .rstn_in(rstn_in),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_re(bus_re), .bus_rdata(bus_rdata),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .err(err), .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // Fall-through FIFO model
    logic [7:0] fmem [256];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = fmem[rd_ptr % 256];
    always @(posedge clk_in) if (fifo_pop) rd_ptr <= rd_ptr + 1;

    // Register file contents seen by reads
    function automatic logic [7:0] rd_val(input logic [7:0] a);
        return (a == 8'h20) ? 8'h5C : (a ^ 8'hC3);
    endfunction
    assign bus_rdata = rd_val(bus_addr);

    // Scoreboard
    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [7:0]  exp_rsp_q[$];
    logic [15:0] wr_log[$];
    int re_seen = 0;
    int err_seen = 0;
    int exp_pulses = 0;
    logic [7:0] exp_cnt = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fmem[wr_ptr % 256] = b;
        wr_ptr++;
    endtask

    // Packet-level model: emits the bytes and the bus/response traffic they imply.
    task automatic send_pkt(input logic wr, input logic [2:0] ign, input logic [7:0] a,
                            input int n, input logic [31:0] dw);
        logic [7:0] hdr, ai, di;
        hdr = {wr, ign, 4'(n - 1)};
        push_byte(hdr);
        push_byte(a);
`ifdef SPDR_CMD_CHKSUM_EN
        push_byte(hdr ^ a ^ 8'hA5);
`endif
        for (int i = 0; i < n; i++) begin
            ai = a + 8'(i);
            if (wr) begin
                di = dw[31 - 8*i -: 8];
                push_byte(di);
                exp_wr_q.push_back({ai, di});
            end else begin
                exp_rd_q.push_back(ai);
                exp_rsp_q.push_back(rd_val(ai));
            end
        end
    endtask

    task automatic note_error();
        exp_pulses++;
        exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while ((exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || exp_rsp_q.size() != 0 ||
                rd_ptr != wr_ptr) && k < 400) begin
            tick();
            k++;
        end
        repeat (3) tick();
        chk({"done_", tag}, 32'(k >= 400), 32'd0);
    endtask

    // Compare process
    logic       prev_v = 1'b0, prev_rdy = 1'b0;
    logic [7:0] prev_d = 8'd0;
    always @(negedge clk_in) begin
        if (!rstn_in) begin
            prev_v = 1'b0;
        end else begin
            if (fifo_pop) chk("pop_when_empty", 32'(fifo_empty), 32'd0);
            if (bus_we) begin
                wr_log.push_back({bus_addr, bus_wdata});
                if (exp_wr_q.size() == 0) chk("wr_unexpected", {bus_addr, bus_wdata}, 32'hFFFF_FFFF);
                else chk("wr", {bus_addr, bus_wdata}, 32'(exp_wr_q.pop_front()));
            end
            if (bus_re) begin
                re_seen++;
                if (exp_rd_q.size() == 0) chk("re_unexpected", 32'(bus_addr), 32'hFFFF_FFFF);
                else chk("re_addr", 32'(bus_addr), 32'(exp_rd_q.pop_front()));
            end
            if (prev_v && !prev_rdy) begin
                chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_hold_data", 32'(rsp_data), 32'(prev_d));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
                else chk("rsp_data", 32'(rsp_data), 32'(exp_rsp_q.pop_front()));
            end
            if (err) err_seen++;
            prev_v   = rsp_valid;
            prev_rdy = rsp_ready;
            prev_d   = rsp_data;
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int base, re0, hold, k, ek;

        // Reset block
        rstn_in   = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_bus_we", 32'(bus_we), 0);
        chk("rst_bus_re", 32'(bus_re), 0);
        chk("rst_bus_addr", 32'(bus_addr), 0);
        chk("rst_bus_wdata", 32'(bus_wdata), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_fifo_pop", 32'(fifo_pop), 0);
        chk("rst_state", 32'(state_dbg), 0);
        rstn_in = 1'b1;
        tick();
        chk("post_rst_we", 32'(bus_we), 0);

        // Write of two bytes at 0x10
        base = wr_log.size();
        send_pkt(1'b1, 3'b000, 8'h10, 2, 32'hAABB_0000);
        wait_done("write");
        chk("t1_count", 32'(wr_log.size() - base), 2);
        chk("t1_wr0", 32'(wr_log[base]), 32'h10AA);
        chk("t1_wr1", 32'(wr_log[base + 1]), 32'h11BB);
        chk("t1_err", 32'(err_cnt), 0);

        // Read with 5 cycles of backpressure
        rsp_ready = 1'b0;
        re0 = re_seen;
        send_pkt(1'b0, 3'b000, 8'h20, 1, 32'd0);
        k = 0;
        while (!rsp_valid && k < 50) begin tick(); k++; end
        chk("t2_valid_seen", 32'(rsp_valid), 1);
        hold = 0;
        repeat (5) begin
            if (rsp_valid && rsp_data == 8'h5C) hold++;
            tick();
        end
        chk("t2_hold_cycles", 32'(hold), 5);
        rsp_ready = 1'b1;
        wait_done("read");
        chk("t2_re_count", 32'(re_seen - re0), 1);
        chk("t2_idle", 32'(state_dbg), 0);

        // Address wrap, HDR[6:4] nonzero
        base = wr_log.size();
        send_pkt(1'b1, 3'b101, 8'hFE, 3, 32'h0102_0300);
        wait_done("wrap");
        chk("t3_wr_fe", 32'(wr_log[base]), 32'hFE01);
        chk("t3_wr_ff", 32'(wr_log[base + 1]), 32'hFF02);
        chk("t3_wr_00", 32'(wr_log[base + 2]), 32'h0003);

        // Back-to-back write then 3-byte wrapping read
        send_pkt(1'b1, 3'b000, 8'h80, 1, 32'h5A00_0000);
        send_pkt(1'b0, 3'b011, 8'hFF, 3, 32'd0);
        wait_done("b2b");

        // Timeout after HDR+ADDR
        base = wr_log.size();
        push_byte(8'h81);
        push_byte(8'h30);
`ifdef SPDR_CMD_CHKSUM_EN
        push_byte(8'h14);
`endif
        note_error();
        repeat (12) tick();
        chk("t5_err_pulses", 32'(err_seen), 32'(exp_pulses));
        chk("t5_err_cnt", 32'(err_cnt), 1);
        chk("t5_no_write", 32'(wr_log.size() - base), 0);
        send_pkt(1'b1, 3'b000, 8'h31, 1, 32'h9900_0000);
        wait_done("after_tmo");

`ifdef SPDR_CMD_CHKSUM_EN
        // Bad checksum on a 2-byte write
        base = wr_log.size();
        push_byte(8'h81);
        push_byte(8'h60);
        push_byte(8'h00);
        push_byte(8'hE1);
        push_byte(8'hE2);
        note_error();
        repeat (12) tick();
        chk("t6_drained", 32'(wr_ptr - rd_ptr), 0);
        chk("t6_no_write", 32'(wr_log.size() - base), 0);
        chk("t6_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        send_pkt(1'b1, 3'b000, 8'h61, 1, 32'h4400_0000);
        wait_done("after_chk");
`endif

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            ek = err_seen;
            push_byte(8'h81);
            push_byte(8'h00);
`ifdef SPDR_CMD_CHKSUM_EN
            push_byte(8'h24);
`endif
            note_error();
            k = 0;
            while (err_seen == ek && k < 20) begin tick(); k++; end
            if (k >= 20) chk("sat_err_missing", 32'(i), 32'hFFFF_FFFF);
            tick();
        end
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
        chk("sat_model_cnt", 32'(err_cnt), 32'(exp_cnt));
        chk("sat_pulses", 32'(err_seen), 32'(exp_pulses));

        // Reset in the middle of a 4-byte write
        base = wr_log.size();
        push_byte(8'h83);
        push_byte(8'h40);
`ifdef SPDR_CMD_CHKSUM_EN
        push_byte(8'h66);
`endif
        push_byte(8'h11);
        exp_wr_q.push_back(16'h4011);
        k = 0;
        while (wr_log.size() == base && k < 50) begin tick(); k++; end
        chk("t7_first_byte", 32'(wr_log.size() - base), 1);
        tick();
        rstn_in = 1'b0;
        #1;
        chk("t7_rst_we", 32'(bus_we), 0);
        chk("t7_rst_addr", 32'(bus_addr), 0);
        chk("t7_rst_wdata", 32'(bus_wdata), 0);
        chk("t7_rst_err_cnt", 32'(err_cnt), 0);
        chk("t7_rst_state", 32'(state_dbg), 0);
        exp_cnt = 8'd0;
        repeat (2) tick();
        rstn_in = 1'b1;
        tick();
        chk("t7_post_rst_we", 32'(bus_we), 0);
        push_byte(8'h80);
        push_byte(8'h50);
`ifdef SPDR_CMD_CHKSUM_EN
        push_byte(8'h75);
`endif
        push_byte(8'h77);
        exp_wr_q.push_back(16'h5077);
        wait_done("after_rst");
        chk("t7_new_pkt", 32'(wr_log[wr_log.size() - 1]), 32'h5077);
        chk("t7_err_cnt", 32'(err_cnt), 0);

        // Final report
        chk("final_err_pulses", 32'(err_seen), 32'(exp_pulses));
        chk("final_wr_q", 32'(exp_wr_q.size()), 0);
        chk("final_rsp_q", 32'(exp_rsp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
